// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator stimulus driver.
// Covers both the default build and the CMP_STIM_DRIVER_TIMEOUT_EN watchdog build.
package cmp_pkg;

    localparam int unsigned CMP_W  = 4;
    localparam int unsigned LFSR_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WD_W   = 8;

    // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7, 5, 4, 3
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

    // Watchdog value seen on the 255th WAIT cycle without ack
    localparam logic [WD_W-1:0] WD_LAST = 8'd254;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        HOLD  = 3'd4
    } cmp_state_e;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_flags_t;

    function automatic cmp_flags_t cmp_expect(input logic [CMP_W-1:0] a,
                                              input logic [CMP_W-1:0] b);
        cmp_flags_t f;
        f.gt = (a > b);
        f.eq = (a == b);
        f.lt = (a < b);
        return f;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/cmp_lfsr8.sv
// 8-bit Fibonacci LFSR, shift left with feedback into bit 0; advances on adv.
module cmp_lfsr8
    import cmp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= seed;
        end else if (adv) begin
            q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/cmp_stim_driver.sv
// Drives operand pairs to a comparator responder and checks its gt/eq/lt flags.
// Optional WAIT watchdog enabled by defining CMP_STIM_DRIVER_TIMEOUT_EN.
module cmp_stim_driver
    import cmp_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = 8'hA5,
    parameter logic [CMP_W-1:0]  DIR_A = 4'b1011,
    parameter logic [CMP_W-1:0]  DIR_B = 4'b1001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_sel,
    input  logic             suspend,
    output logic [CMP_W-1:0] a,
    output logic [CMP_W-1:0] b,
    output logic             req,
    input  logic             ack,
    input  logic             gt,
    input  logic             eq,
    input  logic             lt,
    output logic             busy,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag
);

    cmp_state_e        state_q, state_d;
    logic [CMP_W-1:0]  a_d, b_d;
    logic              req_d, busy_d, err_flag_d;
    logic [CNT_W-1:0]  txn_cnt_d, err_cnt_d;
    cmp_flags_t        cap_q, cap_d;
    logic              lfsr_adv_c;
    logic [LFSR_W-1:0] lfsr_q;
    logic              skip_cmp_c;
    logic              mismatch_c;

    cmp_lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (lfsr_adv_c),
        .seed  (SEED),
        .q     (lfsr_q)
    );

`ifdef CMP_STIM_DRIVER_TIMEOUT_EN
    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;
    assign skip_cmp_c = to_q;
`else
    assign skip_cmp_c = 1'b0;
`endif

    // Wrong flags or a non-one-hot flag set both count as an error
    assign mismatch_c = (cap_q != cmp_expect(a, b)) || !$onehot(cap_q);

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        a_d        = a;
        b_d        = b;
        req_d      = req;
        txn_cnt_d  = txn_cnt;
        err_cnt_d  = err_cnt;
        err_flag_d = err_flag;
        cap_d      = cap_q;
        lfsr_adv_c = 1'b0;
`ifdef CMP_STIM_DRIVER_TIMEOUT_EN
        wd_d       = wd_q;
        to_d       = to_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = DRIVE;
                    err_flag_d = 1'b0;
                end
            end
            DRIVE: begin
                state_d = WAIT;
                req_d   = 1'b1;
                if (mode_sel) begin
                    a_d = DIR_A;
                    b_d = DIR_B;
                end else begin
                    a_d        = lfsr_q[LFSR_W-1:CMP_W];
                    b_d        = lfsr_q[CMP_W-1:0];
                    lfsr_adv_c = 1'b1;
                end
`ifdef CMP_STIM_DRIVER_TIMEOUT_EN
                wd_d = '0;
                to_d = 1'b0;
`endif
            end
            WAIT: begin
                if (ack) begin
                    cap_d   = cmp_flags_t'({gt, eq, lt});
                    req_d   = 1'b0;
                    state_d = CHECK;
                end
`ifdef CMP_STIM_DRIVER_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    req_d      = 1'b0;
                    err_cnt_d  = sat_inc(err_cnt);
                    err_flag_d = 1'b1;
                    to_d       = 1'b1;
                    state_d    = CHECK;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            CHECK: begin
                txn_cnt_d = sat_inc(txn_cnt);
                if (!skip_cmp_c && mismatch_c) begin
                    err_cnt_d  = sat_inc(err_cnt);
                    err_flag_d = 1'b1;
                end
                if (stop) begin
                    state_d = IDLE;
                end else if (suspend) begin
                    state_d = HOLD;
                end else begin
                    state_d = DRIVE;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!suspend) begin
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a        <= '0;
            b        <= '0;
            req      <= 1'b0;
            busy     <= 1'b0;
            txn_cnt  <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
            cap_q    <= '0;
        end else begin
            state_q  <= state_d;
            a        <= a_d;
            b        <= b_d;
            req      <= req_d;
            busy     <= busy_d;
            txn_cnt  <= txn_cnt_d;
            err_cnt  <= err_cnt_d;
            err_flag <= err_flag_d;
            cap_q    <= cap_d;
        end
    end

`ifdef CMP_STIM_DRIVER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end
`endif

endmodule
